// File: rtl/pbypass_pkg.sv
// Shared types and default sizes for the bypass counter array.
// Auto-reload support is controlled by the PBYPASS_AUTO_RELOAD_EN macro.
package pbypass_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_NUM_CH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } ch_state_e;

  // A single channel still needs a one-bit select so the port never collapses to zero width.
  function automatic int ch_sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pbypass_channel.sv
// One bypass channel: a down-counter with a terminal pulse and an optional auto-reload.
// PBYPASS_AUTO_RELOAD_EN builds the reload and mode registers. Without it, every channel is one-shot.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no count in progress; step_en and clear are ignored
//   COUNT | counting down on step_en; terminal pulse when 1 is stepped
module pbypass_channel
  import pbypass_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
`ifdef PBYPASS_AUTO_RELOAD_EN
  input  logic             load_mode,
`endif
  input  logic             step_en,
  input  logic             clear,
  output logic             terminate,
  output logic             busy
);

  ch_state_e        state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] start_value;

`ifdef PBYPASS_AUTO_RELOAD_EN
  logic [CNT_W-1:0] reload;
  logic             mode;
`endif

  // A zero count still needs one enabled step so that the terminal pulse is issued.
  assign start_value = (load_value == '0) ? CNT_W'(1) : load_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      terminate <= 1'b0;
      busy      <= 1'b0;
`ifdef PBYPASS_AUTO_RELOAD_EN
      reload    <= '0;
      mode      <= 1'b0;
`endif
    end else begin
      terminate <= 1'b0;
      if (load) begin
        state <= COUNT;
        count <= start_value;
        busy  <= 1'b1;
`ifdef PBYPASS_AUTO_RELOAD_EN
        reload <= start_value;
        mode   <= load_mode;
`endif
      end else if (state == COUNT) begin
        if (clear) begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end else if (step_en) begin
          if (count == CNT_W'(1)) begin
            terminate <= 1'b1;
`ifdef PBYPASS_AUTO_RELOAD_EN
            if (mode) begin
              count <= reload;
            end else begin
              state <= IDLE;
              count <= '0;
              busy  <= 1'b0;
            end
`else
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
`endif
          end else begin
            count <= count - CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/pbypass_counter_array.sv
// NUM_CH independent bypass counters with a shared load port that is steered by LOAD_CH.
// PBYPASS_AUTO_RELOAD_EN enables per-channel auto-reload. Without it, LOAD_MODE is ignored.
module pbypass_counter_array
  import pbypass_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = ch_sel_width(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              LOAD_COUNT,
  input  logic [CH_W-1:0]   LOAD_CH,
  input  logic [CNT_W-1:0]  COUNT_VALUE,
  input  logic              LOAD_MODE,
  input  logic [NUM_CH-1:0] STEP_EN,
  input  logic [NUM_CH-1:0] CLEAR,
  output logic [NUM_CH-1:0] TERMINATE,
  output logic [NUM_CH-1:0] BUSY
);

  logic [NUM_CH-1:0] load_strobe;

  // A select value of NUM_CH or higher matches no channel, so that load is dropped.
  always_comb begin
    load_strobe = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load_strobe[i] = LOAD_COUNT && (LOAD_CH == CH_W'(i));
    end
  end

`ifndef PBYPASS_AUTO_RELOAD_EN
  logic unused_load_mode;
  assign unused_load_mode = LOAD_MODE;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pbypass_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk        (CLK),
      .rst_n      (RESET_N),
      .load       (load_strobe[g]),
      .load_value (COUNT_VALUE),
`ifdef PBYPASS_AUTO_RELOAD_EN
      .load_mode  (LOAD_MODE),
`endif
      .step_en    (STEP_EN[g]),
      .clear      (CLEAR[g]),
      .terminate  (TERMINATE[g]),
      .busy       (BUSY[g])
    );
  end

endmodule

// File: tb/tb_pbypass_counter_array.sv
// Self-checking bench for pbypass_counter_array: vector table, directed corner sequences, random vs model.
module tb_pbypass_counter_array;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 3;
`ifdef PBYPASS_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              LOAD_COUNT;
  logic [CH_W-1:0]   LOAD_CH;
  logic [CNT_W-1:0]  COUNT_VALUE;
  logic              LOAD_MODE;
  logic [NUM_CH-1:0] STEP_EN;
  logic [NUM_CH-1:0] CLEAR;
  logic [NUM_CH-1:0] TERMINATE;
  logic [NUM_CH-1:0] BUSY;

  pbypass_counter_array #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LOAD_COUNT(LOAD_COUNT), .LOAD_CH(LOAD_CH),
    .COUNT_VALUE(COUNT_VALUE), .LOAD_MODE(LOAD_MODE), .STEP_EN(STEP_EN),
    .CLEAR(CLEAR), .TERMINATE(TERMINATE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Model: remaining enabled steps before the next terminal, per channel.
  bit                m_active [NUM_CH];
  int                m_left   [NUM_CH];
  int                m_period [NUM_CH];
  bit                m_repeat [NUM_CH];
  logic [NUM_CH-1:0] m_term;
  logic [NUM_CH-1:0] m_busy;

  typedef struct {
    bit              ld;
    int              ch;
    int              val;
    bit              md;
    logic [NUM_CH-1:0] st;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] busy;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_active[i] = 1'b0; m_left[i] = 0; m_period[i] = 0; m_repeat[i] = 1'b0;
    end
    m_term = '0;
    m_busy = '0;
  endtask

  task automatic model_step(input bit ld, input int ch, input int val, input bit md,
                            input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] clr);
    m_term = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ld && ch == i) begin
        m_active[i] = 1'b1;
        m_left[i]   = (val == 0) ? 1 : val;
        m_period[i] = m_left[i];
        m_repeat[i] = md && AR;
      end else if (m_active[i]) begin
        if (clr[i]) begin
          m_active[i] = 1'b0;
        end else if (st[i]) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_term[i] = 1'b1;
            if (m_repeat[i]) m_left[i] = m_period[i];
            else             m_active[i] = 1'b0;
          end
        end
      end
      m_busy[i] = m_active[i];
    end
  endtask

  task automatic drive(input bit ld, input int ch, input int val, input bit md,
                       input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] clr);
    LOAD_COUNT  = ld;
    LOAD_CH     = CH_W'(ch);
    COUNT_VALUE = CNT_W'(val);
    LOAD_MODE   = md;
    STEP_EN     = st;
    CLEAR       = clr;
    @(posedge CLK);
    #1;
    model_step(ld, ch, val, md, st, clr);
  endtask

  task automatic tick(input string tag, input bit ld, input int ch, input int val, input bit md,
                      input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] clr);
    drive(ld, ch, val, md, st, clr);
    check({tag, "_term"}, 32'(TERMINATE), 32'(m_term));
    check({tag, "_busy"}, 32'(BUSY), 32'(m_busy));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [NUM_CH-1:0] rclr;

    vecs[0]  = '{1'b1, 0, 5, 1'b0, 4'hf, 4'h0, 4'h0, 4'h1};
    vecs[1]  = '{1'b0, 0, 0, 1'b0, 4'hf, 4'h0, 4'h0, 4'h1};
    vecs[2]  = '{1'b0, 0, 0, 1'b0, 4'hf, 4'h0, 4'h0, 4'h1};
    vecs[3]  = '{1'b0, 0, 0, 1'b0, 4'hf, 4'h0, 4'h0, 4'h1};
    vecs[4]  = '{1'b0, 0, 0, 1'b0, 4'hf, 4'h0, 4'h0, 4'h1};
    vecs[5]  = '{1'b0, 0, 0, 1'b0, 4'hf, 4'h0, 4'h1, 4'h0};
    vecs[6]  = '{1'b0, 0, 0, 1'b0, 4'hf, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{1'b0, 0, 0, 1'b0, 4'hf, 4'hf, 4'h0, 4'h0};
    vecs[8]  = '{1'b1, 4, 3, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[9]  = '{1'b1, 1, 1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h2};
    vecs[10] = '{1'b0, 0, 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h2};
    vecs[11] = '{1'b0, 0, 0, 1'b0, 4'h2, 4'h0, 4'h2, 4'h0};

    RESET_N = 1'b0; LOAD_COUNT = 1'b0; LOAD_CH = '0; COUNT_VALUE = '0;
    LOAD_MODE = 1'b0; STEP_EN = '0; CLEAR = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_term", 32'(TERMINATE), 32'h0);
    check("reset_busy", 32'(BUSY), 32'h0);
    RESET_N = 1'b1;

    // Vector table: one-shot V=5, idle immunity, out-of-range select, V=1.
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].ld, vecs[v].ch, vecs[v].val, vecs[v].md, vecs[v].st, vecs[v].clr);
      check($sformatf("vec%0d_term", v), 32'(TERMINATE), 32'(vecs[v].term));
      check($sformatf("vec%0d_busy", v), 32'(BUSY), 32'(vecs[v].busy));
    end

    // ch1 V=3 auto-reload with STEP_EN held.
    pulses = 0;
    tick("ar_load", 1'b1, 1, 3, 1'b1, 4'h2, 4'h0);
    for (int k = 1; k <= 12; k++) begin
      tick("ar_run", 1'b0, 0, 0, 1'b0, 4'h2, 4'h0);
      check("ar_pulse_phase", 32'(TERMINATE[1]), 32'((k % 3 == 0) && (AR || k == 3)));
      check("ar_busy", 32'(BUSY[1]), 32'(AR || k < 3));
      pulses += int'(TERMINATE[1]);
    end
    check("ar_pulse_count", 32'(pulses), AR ? 32'd4 : 32'd1);
    tick("clr_all", 1'b0, 0, 0, 1'b0, 4'h0, 4'hf);
    check("clr_all_busy", 32'(BUSY), 32'h0);

    // ch2 V=10 with STEP_EN[2] at 50% duty, then V=0.
    tick("duty_load", 1'b1, 2, 10, 1'b0, 4'h0, 4'h0);
    for (int k = 1; k <= 20; k++) begin
      tick("duty_run", 1'b0, 0, 0, 1'b0, (k % 2 == 1) ? 4'h4 : 4'h0, 4'h0);
      check("duty_pulse", 32'(TERMINATE[2]), 32'(k == 19));
    end
    tick("zero_load", 1'b1, 2, 0, 1'b0, 4'h0, 4'h0);
    tick("zero_step", 1'b0, 0, 0, 1'b0, 4'h4, 4'h0);
    check("zero_pulse", 32'(TERMINATE[2]), 32'h1);

    // ch3 V=4 reloaded with V=6 on its terminal edge.
    tick("rl_load", 1'b1, 3, 4, 1'b0, 4'h8, 4'h0);
    for (int k = 1; k <= 3; k++) tick("rl_run", 1'b0, 0, 0, 1'b0, 4'h8, 4'h0);
    tick("rl_reload", 1'b1, 3, 6, 1'b0, 4'h8, 4'h0);
    check("rl_no_pulse", 32'(TERMINATE[3]), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick("rl_after", 1'b0, 0, 0, 1'b0, 4'h8, 4'h0);
      check("rl_pulse", 32'(TERMINATE[3]), 32'(k == 6));
    end

    // ch0 V=8, CLEAR at count 4.
    tick("clr_load", 1'b1, 0, 8, 1'b0, 4'h1, 4'h0);
    for (int k = 1; k <= 4; k++) tick("clr_run", 1'b0, 0, 0, 1'b0, 4'h1, 4'h0);
    tick("clr_hit", 1'b0, 0, 0, 1'b0, 4'h1, 4'h1);
    check("clr_busy", 32'(BUSY[0]), 32'h0);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick("clr_after", 1'b0, 0, 0, 1'b0, 4'h1, 4'h0);
      pulses += int'(TERMINATE[0]);
    end
    check("clr_no_pulse", 32'(pulses), 32'h0);

    // Consecutive loads, then an out-of-range select.
    tick("pair_ld0", 1'b1, 0, 7, 1'b0, 4'hf, 4'h0);
    tick("pair_ld1", 1'b1, 1, 7, 1'b0, 4'hf, 4'h0);
    tick("pair_oor", 1'b1, 5, 2, 1'b1, 4'hf, 4'h0);
    check("pair_oor_busy", 32'(BUSY), 32'h3);
    for (int e = 3; e <= 9; e++) begin
      tick("pair_run", 1'b0, 0, 0, 1'b0, 4'hf, 4'h0);
      check("pair_pulse0", 32'(TERMINATE[0]), 32'(e == 7));
      check("pair_pulse1", 32'(TERMINATE[1]), 32'(e == 8));
    end

    // Simultaneous terminals on two channels.
    tick("sim_ld0", 1'b1, 0, 3, 1'b0, 4'hf, 4'h0);
    tick("sim_ld1", 1'b1, 1, 2, 1'b0, 4'hf, 4'h0);
    tick("sim_run", 1'b0, 0, 0, 1'b0, 4'hf, 4'h0);
    tick("sim_run", 1'b0, 0, 0, 1'b0, 4'hf, 4'h0);
    check("sim_both", 32'(TERMINATE), 32'h3);

    // Reset dropped mid-count clears outputs without waiting for a clock.
    tick("rst_load", 1'b1, 0, 8, 1'b1, 4'h1, 4'h0);
    tick("rst_run", 1'b0, 0, 0, 1'b0, 4'h1, 4'h0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("rst_async_busy", 32'(BUSY), 32'h0);
    check("rst_async_term", 32'(TERMINATE), 32'h0);
    model_reset();
    @(posedge CLK);
    #1;
    check("rst_hold_busy", 32'(BUSY), 32'h0);
    RESET_N = 1'b1;
    tick("rst_first_load", 1'b1, 2, 2, 1'b0, 4'h0, 4'h0);
    check("rst_first_busy", 32'(BUSY), 32'h4);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rclr = '0;
      for (int i = 0; i < NUM_CH; i++) rclr[i] = ($urandom_range(15) == 0);
      tick("rand", ($urandom_range(4) == 0), int'($urandom_range(5)), int'($urandom_range(9)),
           1'($urandom_range(1)), NUM_CH'($urandom), rclr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
